fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the PC and issues requests to instruction memory.
- Drives the IF/ID register's write side: ifid_write, PC+2, instruction word, flush and stall.
- Handles variable-latency memory, hazard holds and branch/jump redirects.
- Holds at most one fetched-but-unconsumed instruction.

Parameters:
- PC_W, 16, PC and address width.
- RESET_PC, 16'h0000, PC value after reset.
- INSTR_BYTES, 2, PC increment per instruction.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- imem_req  out  1  fetch request valid.
- imem_addr  out  PC_W  fetch address.
- imem_ready  in  1  response valid this cycle; request completes.
- imem_data  in  16  instruction word, valid with imem_ready.
- hold  in  1  hazard unit: decode cannot accept.
- redirect  in  1  taken branch/jump resolved.
- redirect_pc  in  PC_W  redirect target.
- halt  in  1  HALT decoded; stop fetching.
- ifid_write  out  1  present an instruction to IF/ID this cycle.
- ifid_pc  out  PC_W  address of instruction + INSTR_BYTES.
- ifid_instr  out  16  instruction word.
- ifid_flush  out  1  squash IF/ID contents (insert NOP).
- ifid_stall  out  1  fetch not delivering this cycle (bubble marker).

Behaviour:
- Reset (rst=0, async), values held until the first clk edge after release:
  - PC=RESET_PC, state=FETCH, buffer empty, pending redirect cleared.
  - imem_req=0, ifid_write=0, ifid_flush=0, ifid_stall=1, ifid_pc=0, ifid_instr=0.
- States: FETCH, WAIT, DISCARD, HALTED.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - imem_ready same cycle: complete (zero-wait memory).
  - Otherwise: next state WAIT.
- WAIT:
  - imem_req and imem_addr held stable until imem_ready; never change an outstanding request.
- Completion with hold=0 and buffer empty:
  - ifid_write=1, ifid_instr=imem_data, ifid_pc=PC+INSTR_BYTES.
  - PC advances; next state FETCH.
- Completion with hold=1:
  - Word and PC+INSTR_BYTES captured into the one-entry buffer; PC advances; imem_req deasserted while the buffer is full.
- Buffer full and hold=0:
  - Buffer drives ifid_write=1 and its outputs; buffer empties; fetch resumes next cycle.
- ifid_stall=1 in any cycle with ifid_write=0 and no redirect.
- Redirect has priority over hold and halt:
  - ifid_flush=1 for exactly that cycle; buffer cleared.
  - No outstanding request: PC=redirect_pc next cycle; state FETCH.
  - Request outstanding: redirect_pc latched, state DISCARD. The arriving response is dropped (no ifid_write); then PC=latched target, state FETCH.
  - A second redirect in DISCARD overwrites the latched target.
- Halt:
  - Finish any outstanding request, deliver it, then enter HALTED.
  - HALTED: imem_req=0, ifid_stall=1. Exit only by redirect or reset.
- Arithmetic: PC+INSTR_BYTES wraps modulo 2^PC_W (16'hFFFE -> 16'h0000); no error flag.
- Reset mid-request: outstanding request abandoned. Memory must tolerate the req drop.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output perf_wait_cnt [15:0], a saturating count (stops at 16'hFFFF) of cycles with imem_req=1 and imem_ready=0.
  - Adds output perf_flush_cnt [15:0], same rules, counting redirect cycles.
  - Both reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package:
  - fetch state enum (FETCH, WAIT, DISCARD, HALTED).
  - NOP encoding constant.
  - Default RESET_PC and INSTR_BYTES constants.
- Sub-module fetch_buf: one-entry PC/instruction holding register with full flag, clear and load.

Test Plan:
- Zero-wait memory, imem_ready=1 always, 4 cycles from RESET_PC=0 -> ifid_write=1 each cycle; ifid_pc=2,4,6,8; imem_addr=0,2,4,6.
- imem_ready delayed 3 cycles at addr 0 -> imem_addr=0 held 4 cycles; ifid_stall=1 for 3 cycles; then ifid_write=1 with ifid_pc=2.
- hold=1 for 2 cycles as word at addr 4 arrives -> word buffered, imem_req=0; after hold drops, ifid_write=1, ifid_pc=6, instruction preserved.
- redirect to 16'h0040 during WAIT at addr 8 -> ifid_flush=1 one cycle; response dropped; next imem_addr=16'h0040.
- PC=16'hFFFE fetch completes -> ifid_pc=16'h0000; next imem_addr=16'h0000.
- rst=0 asserted mid-WAIT -> imem_req=0 and PC=RESET_PC immediately (asynchronously); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage state encoding and default constants
package fetch_unit_pkg;
   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DISCARD, S_HALTED} fetch_state_t;
   localparam logic [15:0] NOP = 16'h0000;
   localparam logic [15:0] DEF_RESET_PC = 16'h0000;
   localparam int DEF_INSTR_BYTES = 2;
endpackage

// File: rtl/fetch_unit_buf.sv
// fetch_buf: one-entry PC/instruction holding register with full flag
module fetch_buf
   import fetch_unit_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] pc_in,
   input  logic [15:0]  instr_in,
   output logic         full,
   output logic [W-1:0] pc,
   output logic [15:0]  instr
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         full  <= 1'b0;
         pc    <= '0;
         instr <= NOP;
      end else if (clr) begin
         full  <= 1'b0;
      end else if (load) begin
         full  <= 1'b1;
         pc    <= pc_in;
         instr <= instr_in;
      end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage driving IF/ID; FETCH_PERF_EN adds perf counters
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                PC_W        = 16,
   parameter logic [PC_W-1:0]   RESET_PC    = DEF_RESET_PC,
   parameter int                INSTR_BYTES = DEF_INSTR_BYTES
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [15:0]     imem_data,
   input  logic            hold,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            halt,
   output logic            ifid_write,
   output logic [PC_W-1:0] ifid_pc,
   output logic [15:0]     ifid_instr,
   output logic            ifid_flush,
   output logic            ifid_stall
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]     perf_wait_cnt,
   output logic [15:0]     perf_flush_cnt
`endif
);
   fetch_state_t state, state_nx;
   logic [PC_W-1:0] pc, pc_nx, tgt, tgt_nx, pc_inc, buf_pc;
   logic [15:0] buf_instr;
   logic run, halt_pend, halt_pend_nx, halt_now, buf_full, buf_clr, buf_load, done, outst;
   // run keeps every output quiet until the first edge after reset release
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= S_FETCH;
         pc        <= RESET_PC;
         tgt       <= '0;
         halt_pend <= 1'b0;
         run       <= 1'b0;
      end else begin
         state     <= state_nx;
         pc        <= pc_nx;
         tgt       <= tgt_nx;
         halt_pend <= halt_pend_nx;
         run       <= 1'b1;
      end
   always_comb begin
      state_nx     = state;
      pc_nx        = pc;
      tgt_nx       = tgt;
      halt_pend_nx = halt_pend;
      if (!run) begin
         state_nx = state;
      end else if (redirect) begin
         halt_pend_nx = 1'b0;
         state_nx     = outst ? S_DISCARD : S_FETCH;
         tgt_nx       = outst ? redirect_pc : tgt;
         pc_nx        = outst ? pc : redirect_pc;
      end else if (state == S_DISCARD) begin
         state_nx = imem_ready ? S_FETCH : S_DISCARD;
         pc_nx    = imem_ready ? tgt : pc;
      end else if (done) begin
         pc_nx        = pc_inc;
         state_nx     = halt_now ? S_HALTED : S_FETCH;
         halt_pend_nx = 1'b0;
      end else if (state == S_FETCH && halt_now) begin
         state_nx     = S_HALTED;
         halt_pend_nx = 1'b0;
      end else if (outst) begin
         state_nx     = S_WAIT;
         halt_pend_nx = halt_now;
      end
   end
   always_comb begin
      pc_inc     = pc + PC_W'(INSTR_BYTES);
      halt_now   = halt | halt_pend;
      imem_req   = run & ((state == S_FETCH & !buf_full & !halt_now) | state == S_WAIT | state == S_DISCARD);
      imem_addr  = pc;
      outst      = imem_req & !imem_ready;
      done       = imem_req & imem_ready & (state != S_DISCARD);
      ifid_flush = run & redirect;
      ifid_write = !ifid_flush & !hold & (buf_full | done);
      ifid_pc    = !ifid_write ? '0 : buf_full ? buf_pc : pc_inc;
      ifid_instr = !ifid_write ? NOP : buf_full ? buf_instr : imem_data;
      ifid_stall = !ifid_write & !ifid_flush;
      buf_clr    = ifid_flush | (buf_full & !hold);
      buf_load   = !ifid_flush & done & hold;
   end
   fetch_buf #(.W(PC_W)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .clr      (buf_clr),
      .load     (buf_load),
      .pc_in    (pc_inc),
      .instr_in (imem_data),
      .full     (buf_full),
      .pc       (buf_pc),
      .instr    (buf_instr)
   );
`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         perf_wait_cnt  <= '0;
         perf_flush_cnt <= '0;
      end else begin
         perf_wait_cnt  <= perf_wait_cnt + 16'(outst && perf_wait_cnt != 16'hFFFF);
         perf_flush_cnt <= perf_flush_cnt + 16'(ifid_flush && perf_flush_cnt != 16'hFFFF);
      end
`endif
endmodule
